// File: rtl/reg_write_arbiter_pkg.sv
// rtl/reg_write_arbiter_pkg.sv - register map, address limit and FSM encoding for the write arbiter
package reg_write_arbiter_pkg;

    localparam logic [6:0] ADDR_EN_OUT_LO   = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_HI   = 7'h01;
    localparam logic [6:0] ADDR_EN_PWM_LO   = 7'h02;
    localparam logic [6:0] ADDR_EN_PWM_HI   = 7'h03;
    localparam logic [6:0] ADDR_PWM_DUTY    = 7'h04;
    localparam logic [6:0] MAX_ADDR_DEFAULT = 7'h04;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_COMMIT = 1'b1
    } state_t;

endpackage

// File: rtl/reg_write_arbiter_if.sv
// rtl/reg_write_arbiter_if.sv - two-requester register write request bus
interface reg_write_arbiter_if;

    logic       req0_valid;
    logic [6:0] req0_addr;
    logic [7:0] req0_data;
    logic       req0_ready;
    logic       req1_valid;
    logic [6:0] req1_addr;
    logic [7:0] req1_data;
    logic       req1_ready;

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        input  req0_ready, req1_ready
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        output req0_ready, req1_ready
    );

endinterface

// File: rtl/reg_write_arbiter_rr_arb2.sv
// rtl/reg_write_arbiter_rr_arb2.sv - two-way round-robin grant with last-grant memory
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant,
    output logic       grant_idx
);

    logic last_grant_q;

    // On a tie the requester not served last wins.
    always_comb begin
        grant_idx = 1'b0;
        grant     = 2'b00;
        if (req == 2'b11) begin
            grant_idx = ~last_grant_q;
        end else if (req[1]) begin
            grant_idx = 1'b1;
        end
        if (req != 2'b00) begin
            grant = grant_idx ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b1;
        end else if (update && (req != 2'b00)) begin
            last_grant_q <= grant_idx;
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - arbitrates two register write requesters into a five-register bank
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter logic [6:0] MAX_ADDR = MAX_ADDR_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    reg_write_arbiter_if.slave req,
    output logic [7:0]         en_reg_out_7_0,
    output logic [7:0]         en_reg_out_15_8,
    output logic [7:0]         en_reg_pwm_7_0,
    output logic [7:0]         en_reg_pwm_15_8,
    output logic [7:0]         pwm_duty_cycle,
    output logic               wr_done,
    output logic               wr_src,
    output logic               err_addr,
    output logic               busy
);

    state_t     state_q;
    state_t     state_d;
    logic [6:0] addr_q;
    logic [7:0] data_q;
    logic       src_q;
    logic [1:0] grant;
    logic       grant_idx;
    logic       accept;

    rr_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       ({req.req1_valid, req.req0_valid}),
        .update    (accept),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!rst && (grant != 2'b00)) begin
                    accept  = 1'b1;
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    assign req.req0_ready = accept & grant[0];
    assign req.req1_ready = accept & grant[1];
    assign busy           = (state_q == ST_COMMIT);

    // Reset during COMMIT wins over the commit, so a pending write is dropped silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            addr_q          <= 7'h00;
            data_q          <= 8'h00;
            src_q           <= 1'b0;
            en_reg_out_7_0  <= 8'h00;
            en_reg_out_15_8 <= 8'h00;
            en_reg_pwm_7_0  <= 8'h00;
            en_reg_pwm_15_8 <= 8'h00;
            pwm_duty_cycle  <= 8'h00;
            wr_done         <= 1'b0;
            wr_src          <= 1'b0;
            err_addr        <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_done  <= 1'b0;
            err_addr <= 1'b0;
            if (accept) begin
                addr_q <= grant_idx ? req.req1_addr : req.req0_addr;
                data_q <= grant_idx ? req.req1_data : req.req0_data;
                src_q  <= grant_idx;
            end
            if (state_q == ST_COMMIT) begin
                wr_src <= src_q;
                if (addr_q <= MAX_ADDR) begin
                    wr_done <= 1'b1;
                    case (addr_q)
                        ADDR_EN_OUT_LO: en_reg_out_7_0  <= data_q;
                        ADDR_EN_OUT_HI: en_reg_out_15_8 <= data_q;
                        ADDR_EN_PWM_LO: en_reg_pwm_7_0  <= data_q;
                        ADDR_EN_PWM_HI: en_reg_pwm_15_8 <= data_q;
                        ADDR_PWM_DUTY:  pwm_duty_cycle  <= data_q;
                        default: ;
                    endcase
                end else begin
                    err_addr <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb/tb_reg_write_arbiter.sv - self-checking bench for reg_write_arbiter
module tb_reg_write_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reg_write_arbiter_if bus ();

    logic [7:0] r_out_lo, r_out_hi, r_pwm_lo, r_pwm_hi, r_duty;
    logic       wr_done, wr_src, err_addr, busy;

    reg_write_arbiter dut (
        .clk             (clk),
        .rst             (rst),
        .req             (bus),
        .en_reg_out_7_0  (r_out_lo),
        .en_reg_out_15_8 (r_out_hi),
        .en_reg_pwm_7_0  (r_pwm_lo),
        .en_reg_pwm_15_8 (r_pwm_hi),
        .pwm_duty_cycle  (r_duty),
        .wr_done         (wr_done),
        .wr_src          (wr_src),
        .err_addr        (err_addr),
        .busy            (busy)
    );

    typedef struct {
        int         src;
        logic [6:0] addr;
        logic [7:0] data;
        bit         err;
        int         due;
    } exp_t;

    typedef struct {
        int         src;
        logic [6:0] addr;
        logic [7:0] data;
        bit         err;
    } vec_t;

    exp_t       sb[$];
    int         grant_log[$];
    int         acc_log[$];
    logic [7:0] model[5];
    int         n_checks = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         both_ready = 0;
    int         rst_ready = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] dut_reg(input int i);
        case (i)
            0: return r_out_lo;
            1: return r_out_hi;
            2: return r_pwm_lo;
            3: return r_pwm_hi;
            4: return r_duty;
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    exp_t mon_e;
    always @(negedge clk) begin
        if (bus.req0_ready && bus.req1_ready) both_ready++;
        if (rst && (bus.req0_ready || bus.req1_ready)) rst_ready++;
        if (!rst) begin
            if (sb.size() > 0 && sb[0].due < cyc) begin
                check("missing_pulse", cyc, sb[0].due);
                void'(sb.pop_front());
            end
            if (wr_done || err_addr) begin
                if (sb.size() == 0) begin
                    check("unexpected_pulse", {wr_done, err_addr}, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("pulse_cycle", cyc, mon_e.due);
                    check("wr_done", wr_done, !mon_e.err);
                    check("err_addr", err_addr, mon_e.err);
                    check("wr_src", wr_src, mon_e.src);
                    if (!mon_e.err) model[mon_e.addr] = mon_e.data;
                    for (int i = 0; i < 5; i++) check($sformatf("reg%0d", i), dut_reg(i), model[i]);
                end
            end
        end
    end

    task automatic set_req(input int src, input logic v, input logic [6:0] a, input logic [7:0] d);
        if (src == 0) begin
            bus.req0_valid = v; bus.req0_addr = a; bus.req0_data = d;
        end else begin
            bus.req1_valid = v; bus.req1_addr = a; bus.req1_data = d;
        end
    endtask

    task automatic drive_req(input int src, input logic [6:0] a, input logic [7:0] d, input bit err);
        exp_t e;
        bit   got = 0;
        set_req(src, 1'b1, a, d);
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if ((src == 0) ? bus.req0_ready : bus.req1_ready) begin
                got = 1;
                e.src = src; e.addr = a; e.data = d; e.err = err; e.due = cyc + 2;
                sb.push_back(e);
                grant_log.push_back(src);
                acc_log.push_back(cyc);
            end
        end
        if (!got) check("ready_timeout", 0, 1);
        @(posedge clk); #1;
        set_req(src, 1'b0, 7'h00, 8'h00);
    endtask

    task automatic drain();
        repeat (3) @(posedge clk);
        #1;
        check("drain", sb.size(), 0);
        sb.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_req(0, 1'b0, 7'h00, 8'h00);
        set_req(1, 1'b0, 7'h00, 8'h00);
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) check($sformatf("rst_reg%0d", i), dut_reg(i), 8'h00);
        check("rst_wr_done", wr_done, 0);
        check("rst_err_addr", err_addr, 0);
        check("rst_busy", busy, 0);
        check("rst_wr_src", wr_src, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        grant_log.delete();
        acc_log.delete();
        for (int i = 0; i < 5; i++) model[i] = 8'h00;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t tbl[9];

    initial begin
        tbl = '{
            '{0, 7'h04, 8'hA5, 1'b0},
            '{1, 7'h05, 8'hFF, 1'b1},
            '{0, 7'h00, 8'h5A, 1'b0},
            '{1, 7'h01, 8'hC3, 1'b0},
            '{0, 7'h02, 8'h0F, 1'b0},
            '{1, 7'h03, 8'hF0, 1'b0},
            '{0, 7'h7F, 8'h12, 1'b1},
            '{1, 7'h04, 8'h99, 1'b0},
            '{0, 7'h06, 8'h77, 1'b1}
        };
        rst = 1'b1;
        set_req(0, 1'b0, 7'h00, 8'h00);
        set_req(1, 1'b0, 7'h00, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        for (int i = 0; i < 9; i++) begin
            drive_req(tbl[i].src, tbl[i].addr, tbl[i].data, tbl[i].err);
            drain();
            check($sformatf("tbl%0d_wr_src", i), wr_src, tbl[i].src);
            if (!tbl[i].err) check($sformatf("tbl%0d_reg", i), dut_reg(int'(tbl[i].addr)), tbl[i].data);
        end

        // Simultaneous requests straight after reset: requester 0 wins the first tie.
        do_reset();
        fork
            drive_req(0, 7'h00, 8'h11, 1'b0);
            drive_req(1, 7'h01, 8'h22, 1'b0);
        join
        drain();
        check("tie_first", grant_log[0], 0);
        check("tie_second", grant_log[1], 1);
        check("tie_gap", acc_log[1] - acc_log[0], 2);
        check("tie_out_lo", r_out_lo, 8'h11);
        check("tie_out_hi", r_out_hi, 8'h22);

        grant_log.delete();
        acc_log.delete();
        fork
            begin
                drive_req(0, 7'h02, 8'h10, 1'b0);
                drive_req(0, 7'h02, 8'h30, 1'b0);
            end
            begin
                drive_req(1, 7'h03, 8'h20, 1'b0);
                drive_req(1, 7'h03, 8'h40, 1'b0);
            end
        join
        drain();
        check("alt_count", grant_log.size(), 4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++) begin
            check($sformatf("alt_grant%0d", i), grant_log[i], i % 2);
            if (i > 0) check($sformatf("alt_gap%0d", i), acc_log[i] - acc_log[i-1], 2);
        end
        check("alt_pwm_lo", r_pwm_lo, 8'h30);
        check("alt_pwm_hi", r_pwm_hi, 8'h40);

        // Reset arriving during COMMIT must drop the write and produce no pulse.
        do_reset();
        set_req(0, 1'b1, 7'h02, 8'h3C);
        @(negedge clk);
        check("rc_ready", bus.req0_ready, 1);
        @(posedge clk); #1;
        set_req(0, 1'b0, 7'h00, 8'h00);
        rst = 1'b1;
        set_req(1, 1'b1, 7'h01, 8'h55);
        @(negedge clk);
        check("rc_busy_before", busy, 1);
        @(negedge clk);
        check("rc_ready_in_rst", bus.req1_ready, 0);
        @(posedge clk); #1;
        set_req(1, 1'b0, 7'h00, 8'h00);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rc_no_pulse", {wr_done, err_addr}, 0);
        end
        check("rc_idle", busy, 0);
        check("rc_pwm_lo", r_pwm_lo, 8'h00);
        @(posedge clk); #1;

        acc_log.delete();
        drive_req(1, 7'h03, 8'h01, 1'b0);
        drive_req(1, 7'h03, 8'h80, 1'b0);
        drain();
        check("b2b_gap", (acc_log.size() == 2) ? acc_log[1] - acc_log[0] : -1, 2);
        check("b2b_pwm_hi", r_pwm_hi, 8'h80);

        check("never_both_ready", both_ready, 0);
        check("ready_during_rst", rst_ready, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
